// File: rtl/weight_buf_ctrl.sv
// weight_buf_ctrl: sequencer and sole port owner of the 128-bit weight buffer SRAM.
//   Idle : forwards single-word fill writes (wr_*) straight onto the buffer pins.
//   Burst: on start, reads len consecutive words from base_addr (address wraps at
//          2^AW) and presents them on w_valid/w_data/w_row, one word per cycle.
// Ports:
//   CLK, RSTN                   clock, asynchronous active-low reset
//   start, base_addr, len       burst request (sampled only while idle)
//   busy, done                  burst in progress / one-cycle completion pulse
//   wr_valid/ready/addr/data    fill-write port (ready only while idle)
//   w_valid, w_data, w_row      weight stream to the systolic-array loader
//   buf_CEN/WEN/A/D/RETN, buf_Q buffer SRAM pins (active-low enables, registered Q)
module weight_buf_ctrl #(
  parameter int AW = 13,
  parameter int DW = 128,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          w_valid,
  output logic [DW-1:0] w_data,
  output logic [CW-1:0] w_row,
  output logic          buf_CEN,
  output logic          buf_WEN,
  output logic [AW-1:0] buf_A,
  output logic [DW-1:0] buf_D,
  output logic          buf_RETN,
  input  logic [DW-1:0] buf_Q
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] base_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] issue_cnt;
  logic          rd_pend;
  logic          retn_q;
  logic          last_issue;

  assign last_issue = (issue_cnt == len_q - 1'b1);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      rd_pend   <= 1'b0;
      w_row     <= '0;
      retn_q    <= 1'b0;
    end else begin
      retn_q  <= 1'b1;
      // Buffer Q is registered, so data for a read issued now is valid next cycle.
      rd_pend <= (state == READ);
      if (rd_pend) w_row <= w_row + 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            len_q     <= len;
            issue_cnt <= '0;
            w_row     <= '0;
            state     <= (len == '0) ? DONE : READ;
          end
        end
        READ: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (last_issue) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    w_valid  = rd_pend;
    w_data   = buf_Q;
    buf_RETN = retn_q;
    wr_ready = 1'b0;
    buf_CEN  = 1'b1;
    buf_WEN  = 1'b1;
    buf_A    = '0;
    buf_D    = '0;
    unique case (state)
      IDLE: begin
        // Fill writes pass straight through; held off until retention is up.
        wr_ready = retn_q;
        buf_WEN  = ~(wr_valid & retn_q);
        buf_A    = wr_addr;
        buf_D    = wr_data;
      end
      READ: begin
        buf_CEN = ~retn_q;
        // Truncation to AW bits gives the wrap past the top of the buffer.
        buf_A   = base_q + AW'(issue_cnt);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_weight_buf_ctrl.sv
// Self-checking bench for weight_buf_ctrl: behavioural SRAM, a cycle-offset
// reference model of the burst timing with an expected-contents memory, literal
// scenario checks, and a randomized phase.
module tb_weight_buf_ctrl;
  localparam int AW = 13;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] PAT = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A0;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] len;
  logic          busy, done;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic [CW-1:0] w_row;
  logic          buf_CEN, buf_WEN, buf_RETN;
  logic [AW-1:0] buf_A;
  logic [DW-1:0] buf_D;
  logic [DW-1:0] buf_Q;

  int errors = 0;
  int checks = 0;

  weight_buf_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .w_valid(w_valid), .w_data(w_data),
    .w_row(w_row), .buf_CEN(buf_CEN), .buf_WEN(buf_WEN), .buf_A(buf_A),
    .buf_D(buf_D), .buf_RETN(buf_RETN), .buf_Q(buf_Q)
  );

  always #5 CLK = ~CLK;

  task automatic lcheck(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buffer SRAM: write when WEN low, registered read when CEN low and WEN high.
  logic [DW-1:0] sram [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    buf_Q = '0;
    forever begin
      @(posedge CLK);
      if (!buf_WEN) sram[buf_A] = buf_D;
      else if (!buf_CEN) buf_Q <= sram[buf_A];
    end
  end

  // Reference model: m_t = cycles since the accepted start (-1 when idle).
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int            m_t;
  logic [AW-1:0] m_base;
  logic [CW-1:0] m_len;
  logic          m_retn;
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_t = -1; m_base = '0; m_len = '0; m_retn = 1'b0;
    forever begin
      @(posedge CLK or negedge RSTN);
      if (!RSTN) begin
        m_t    <= -1;
        m_retn <= 1'b0;
      end else begin
        m_retn <= 1'b1;
        if (m_t < 0) begin
          if (m_retn && wr_valid) ref_mem[wr_addr] <= wr_data;
          if (start) begin
            m_t    <= 1;
            m_base <= base_addr;
            m_len  <= len;
          end
        end else if ((m_len == 0 && m_t == 1) || m_t == int'(m_len) + 2) begin
          m_t <= -1;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge CLK) begin
    bit idle, e_read, e_wv, e_done;
    logic [AW-1:0] ea;
    if (!RSTN) begin
      lcheck("rst_busy", busy, 1'b0);
      lcheck("rst_done", done, 1'b0);
      lcheck("rst_wvalid", w_valid, 1'b0);
      lcheck("rst_wrow", w_row, '0);
      lcheck("rst_cen", buf_CEN, 1'b1);
      lcheck("rst_wen", buf_WEN, 1'b1);
      lcheck("rst_retn", buf_RETN, 1'b0);
      lcheck("rst_wready", wr_ready, 1'b0);
    end else begin
      idle   = (m_t < 0);
      e_done = !idle && ((m_len == 0) ? (m_t == 1) : (m_t == int'(m_len) + 2));
      e_read = !idle && m_len != 0 && m_t >= 1 && m_t <= int'(m_len);
      e_wv   = !idle && m_t >= 2 && m_t <= int'(m_len) + 1;
      lcheck("m_busy", busy, !idle);
      lcheck("m_done", done, e_done);
      lcheck("m_wvalid", w_valid, e_wv);
      lcheck("m_cen", buf_CEN, !e_read);
      lcheck("m_wen", buf_WEN, idle ? !(wr_valid && m_retn) : 1'b1);
      lcheck("m_wready", wr_ready, idle && m_retn);
      lcheck("m_retn", buf_RETN, m_retn);
      if (e_read) begin
        ea = m_base + AW'(m_t - 1);
        lcheck("m_rd_addr", buf_A, ea);
      end
      if (idle && wr_valid && m_retn) begin
        lcheck("m_wr_addr", buf_A, wr_addr);
        lcheck("m_wr_data", buf_D, wr_data);
      end
      if (e_wv) begin
        ea = m_base + AW'(m_t - 2);
        lcheck("m_wrow", w_row, CW'(m_t - 2));
        lcheck("m_wdata", w_data, ref_mem[ea]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Fill 0..3 with PAT+i, then burst base=0 len=4 with literal timing checks.
  task automatic fill_burst(input string tag);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = PAT + DW'(i);
      tick();
    end
    wr_valid = 1'b0;
    start = 1'b1; base_addr = '0; len = 8'd4;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      @(negedge CLK);
      lcheck($sformatf("%s_busy_c%0d", tag, c), busy, (c >= 1 && c <= 6));
      lcheck($sformatf("%s_wv_c%0d", tag, c), w_valid, (c >= 2 && c <= 5));
      lcheck($sformatf("%s_done_c%0d", tag, c), done, (c == 6));
      if (c >= 2 && c <= 5) begin
        lcheck($sformatf("%s_row_c%0d", tag, c), w_row, CW'(c - 2));
        lcheck($sformatf("%s_data_c%0d", tag, c), w_data, PAT + DW'(c - 2));
      end
    end
    lcheck({tag, "_ready_after"}, wr_ready, 1'b1);
  endtask

  initial begin
    logic [AW-1:0] wrap_a [4];
    logic [DW-1:0] wdat;
    int ndone, nwv, ncen;
    wrap_a[0] = 13'd8190; wrap_a[1] = 13'd8191; wrap_a[2] = 13'd0; wrap_a[3] = 13'd1;
    RSTN = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    lcheck("reset_retn", buf_RETN, 1'b0);
    lcheck("reset_wready", wr_ready, 1'b0);
    tick();
    RSTN = 1'b1;
    lcheck("retn_still_low", buf_RETN, 1'b0);
    tick();
    lcheck("retn_up", buf_RETN, 1'b1);

    fill_burst("fill");

    // Wrap past the top of the address space.
    start = 1'b1; base_addr = 13'd8190; len = 8'd4;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      @(negedge CLK);
      if (c <= 4) lcheck($sformatf("wrap_addr_c%0d", c), buf_A, wrap_a[c-1]);
      if (c >= 2 && c <= 5) lcheck($sformatf("wrap_row_c%0d", c), w_row, CW'(c - 2));
    end

    // Write held during a len=3 burst stalls until the first idle cycle.
    start = 1'b1; base_addr = '0; len = 8'd3;
    wdat = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
      wr_valid = 1'b1; wr_addr = 13'd20; wr_data = wdat;
      @(negedge CLK);
      lcheck($sformatf("stall_ready_c%0d", c), wr_ready, (c == 6));
      lcheck($sformatf("stall_wen_c%0d", c), buf_WEN, (c != 6));
    end
    tick();
    wr_valid = 1'b0;

    // Same-cycle write and start: the read sees the new data.
    wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 128'h55;
    start = 1'b1; base_addr = 13'd5; len = 8'd1;
    tick();
    wr_valid = 1'b0; start = 1'b0;
    tick();
    @(negedge CLK);
    lcheck("same_cycle_wv", w_valid, 1'b1);
    lcheck("same_cycle_data", w_data, 128'h55);
    tick(); tick();

    // Read back the stalled write.
    start = 1'b1; base_addr = 13'd20; len = 8'd1;
    tick(); start = 1'b0;
    tick();
    @(negedge CLK);
    lcheck("stall_readback", w_data, wdat);
    tick(); tick();

    // len=0: done in cycle 1, no buffer access.
    start = 1'b1; base_addr = 13'd3; len = 8'd0;
    ncen = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
      @(negedge CLK);
      if (!buf_CEN) ncen++;
      if (c == 1) begin
        lcheck("len0_done", done, 1'b1);
        lcheck("len0_busy", busy, 1'b1);
      end
      if (c == 2) lcheck("len0_idle", busy, 1'b0);
    end
    lcheck("len0_no_cen", ncen, 0);

    // Start pulsed mid-burst is ignored.
    start = 1'b1; base_addr = 13'd0; len = 8'd5;
    ndone = 0; nwv = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = (c == 2);
      base_addr = 13'd100; len = 8'd3;
      @(negedge CLK);
      if (done) ndone++;
      if (w_valid) nwv++;
    end
    lcheck("midstart_done_count", ndone, 1);
    lcheck("midstart_word_count", nwv, 5);

    // Reset in cycle 3 of a len=8 burst.
    start = 1'b1; base_addr = 13'd0; len = 8'd8;
    tick(); start = 1'b0;
    tick(); tick();
    RSTN = 1'b0;
    #1;
    lcheck("abort_busy", busy, 1'b0);
    lcheck("abort_wvalid", w_valid, 1'b0);
    lcheck("abort_wrow", w_row, '0);
    lcheck("abort_cen", buf_CEN, 1'b1);
    lcheck("abort_retn", buf_RETN, 1'b0);
    lcheck("abort_wready", wr_ready, 1'b0);
    tick(); tick();
    RSTN = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) ndone++;
    end
    lcheck("abort_no_done", ndone, 0);
    fill_burst("post");

    // Randomized traffic checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 799) == 0) begin
        RSTN = 1'b0;
        tick(); tick();
        RSTN = 1'b1;
      end
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                              : AW'(8180 + $urandom_range(0, 11));
      wr_data   = {$urandom, $urandom, $urandom, $urandom};
      start     = ($urandom_range(0, 7) == 0);
      base_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                              : AW'(8180 + $urandom_range(0, 11));
      len       = CW'($urandom_range(0, 12));
    end
    start = 1'b0; wr_valid = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_buf_ctrl.md
# weight_buf_ctrl

Sequencer and port arbiter for the 128-bit weight buffer SRAM. It accepts single-word fill writes from the host/DMA side. On a start pulse it streams a burst of consecutive weight words out of the buffer to the systolic-array weight loader, tagging each word with its row index. It owns every buffer control pin, so no other block drives the weight buffer.

## Interface
Parameters:
- AW, 13, buffer address width
- DW, 128, buffer/weight word width
- CW, 8, burst-length width (max burst 2^CW−1 words)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  asynchronous active-low reset
- start  in  1  burst request, sampled only when busy=0
- base_addr  in  AW  first buffer address of burst
- len  in  CW  number of words in burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- wr_valid  in  1  fill-write request
- wr_ready  out  1  fill-write accepted this cycle
- wr_addr  in  AW  fill-write address
- wr_data  in  DW  fill-write data
- w_valid  out  1  w_data holds a weight word this cycle
- w_data  out  DW  weight word
- w_row  out  CW  index (0..len−1) of the word on w_data
- buf_CEN  out  1  buffer chip enable, active low
- buf_WEN  out  1  buffer write enable, active low
- buf_A  out  AW  buffer address
- buf_D  out  DW  buffer write data
- buf_RETN  out  1  buffer retention, 0 = hold/inactive
- buf_Q  in  DW  buffer registered read data

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - wr_ready=1.
  - buf_WEN=~wr_valid, buf_CEN=1, buf_A=wr_addr, buf_D=wr_data, all combinational.
  - The write commits at the same edge.
- Start in IDLE:
  - start=1 with len≠0 latches base_addr and len, clears the issue counter and row counter, and moves to READ.
  - start=1 with len=0 moves directly to DONE; no reads are issued.
- READ:
  - buf_CEN=0, buf_WEN=1, buf_A=(base_addr+issue_cnt) mod 2^AW, so addresses wrap past 2^AW−1 to 0.
  - issue_cnt increments every cycle.
  - After the issue with issue_cnt=len−1, move to DRAIN.
  - wr_ready=0; writes stall and must hold wr_valid.
- DRAIN: buf_CEN=1, wr_ready=0; waits one cycle for the last read data, then moves to DONE.
- DONE: done=1 for one cycle, wr_ready=0, then moves to IDLE.
- busy=1 in READ, DRAIN and DONE.
- Read return path:
  - rd_pend is a 1-cycle registered copy of "read issued".
  - w_valid=rd_pend.
  - w_data=buf_Q, a combinational pass-through.
  - w_row is a counter that increments on each w_valid.
- start while busy=1 is ignored and is not queued.
- start and wr_valid in the same IDLE cycle: the write commits and the start is accepted; reads begin the next cycle.
- buf_RETN is a register: 0 in reset, 1 from the first CLK edge after RSTN deasserts. While buf_RETN=0, buf_CEN=buf_WEN=1 and wr_ready=0.
- Outside IDLE, buf_D and buf_A carry no write data; buf_WEN=1.

## Timing
- Reset values, applied immediately on RSTN=0 at any point including mid-burst:
  - State returns to IDLE; no done pulse for the aborted burst.
  - busy=0, done=0, w_valid=0, w_row=0.
  - buf_CEN=1, buf_WEN=1, buf_RETN=0, wr_ready=0.
- Start accepted at edge E0 (cycle 0). Read k is issued in cycle 1+k. w_valid and word k appear in cycle 2+k.
- DRAIN occupies cycle len+1. done is in cycle len+2. IDLE and wr_ready=1 resume in cycle len+3.
- Total: busy is high for len+2 cycles; back-to-back bursts have at least 1 IDLE cycle between them.
- len=0: busy=1 and done=1 in cycle 1 only; no buffer accesses.
- A write issued in IDLE has its data readable by a burst started in the same cycle, because the write edge precedes the first read edge.
- There is no backpressure on w_valid; the consumer must take one word per cycle.

## Test plan
- Fill, then burst:
  - Stimulus: write addr 0..3 with data 0x…A0..A3, then start with base=0, len=4.
  - Required response: w_valid in cycles 2..5 with w_row 0..3 and w_data A0..A3; done in cycle 6; busy high in cycles 1..6.
- Wrap:
  - Stimulus: base=8190, len=4.
  - Required response: buf_A sequence 8190, 8191, 0, 1; w_row 0..3.
- Write stall:
  - Stimulus: wr_valid held from cycle 1 of a len=3 burst.
  - Required response: wr_ready=0 through done; write commits in cycle 6 (first IDLE); buf_WEN=1 throughout the burst.
- Same-cycle start and write:
  - Stimulus: in IDLE, write addr 5 = 0x55 together with start base=5, len=1.
  - Required response: w_data=0x55 in cycle 2.
- len=0 and ignored start:
  - Stimulus: start with len=0; separately, pulse start mid-burst.
  - Required response: for len=0, done in cycle 1 and buf_CEN never low. For the mid-burst start, no extra words and exactly one done.
- Reset mid-burst:
  - Stimulus: assert RSTN=0 in cycle 3 of a len=8 burst.
  - Required response: outputs at reset values immediately; no done; a post-reset burst behaves as in the first scenario.
